// File: rtl/db15_serial_joy.sv
// Serial DB15 joystick receiver: strobes an external 24-bit PISO chain and
// publishes two active-high 12-button words, optionally requiring two equal frames.
module db15_serial_joy #(
    parameter int unsigned DIV    = 32,
    parameter int unsigned GAP    = 256,
    parameter bit          FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [15:0] GAP_M1 = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

    typedef enum logic [2:0] {
        S_LOAD, S_LATCH, S_SHIFT_LO, S_SHIFT_HI, S_DONE, S_GAP
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [23:0] cap_q, cap_d;
    logic [23:0] prev_q, prev_d;
    logic [23:0] joy_q, joy_d;
    logic [1:0]  sync_q;
    logic        jclk_q, jload_q, done_q;
    logic        last;

    assign last = (cnt_q == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= DIV_M1;
            idx_q   <= 5'd0;
            cap_q   <= '0;
            prev_q  <= '0;
            joy_q   <= '0;
            sync_q  <= 2'b11;
            jclk_q  <= 1'b0;
            jload_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            prev_q  <= prev_d;
            joy_q   <= joy_d;
            sync_q  <= {sync_q[0], JOY_DATA};
            // Strobes are decoded from the current state and registered, so the
            // pins trail the FSM by one cycle but hold each phase for DIV cycles.
            jclk_q  <= (state_q == S_SHIFT_HI);
            jload_q <= (state_q != S_LOAD);
            done_q  <= (state_q == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? cnt_q : cnt_q - 16'd1;
        idx_d   = idx_q;
        cap_d   = cap_q;
        prev_d  = prev_q;
        joy_d   = joy_q;
        case (state_q)
            S_LOAD: if (last) begin
                state_d = S_LATCH;
                cnt_d   = DIV_M1;
            end
            S_LATCH: if (last) begin
                state_d = S_SHIFT_LO;
                cnt_d   = DIV_M1;
                idx_d   = 5'd0;
            end
            S_SHIFT_LO: if (last) begin
                cap_d[idx_q] = ~sync_q[1];
                state_d      = S_SHIFT_HI;
                cnt_d        = DIV_M1;
            end
            S_SHIFT_HI: if (last) begin
                if (idx_q == 5'd23) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_SHIFT_LO;
                    cnt_d   = DIV_M1;
                end
            end
            S_DONE: begin
                prev_d = cap_q;
                if (!FILTER || (cap_q == prev_q))
                    joy_d = cap_q;
                if (GAP == 0) begin
                    state_d = S_LOAD;
                    cnt_d   = DIV_M1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_M1;
                end
            end
            S_GAP: if (last) begin
                state_d = S_LOAD;
                cnt_d   = DIV_M1;
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = DIV_M1;
            end
        endcase
    end

    assign JOY_CLK    = jclk_q;
    assign JOY_LOAD   = jload_q;
    assign frame_done = done_q;
    assign joystick1  = {4'b0000, joy_q[11:0]};
    assign joystick2  = {4'b0000, joy_q[23:12]};

endmodule

// File: tb/tb_db15_serial_joy.sv
// Scoreboard bench: unfiltered and filtered receivers each read a modelled
// 24-bit PISO chain; expected words are queued per frame and popped on frame_done.
module tb_db15_serial_joy;

    localparam int DIV    = 4;
    localparam int GAP    = 8;
    localparam int PERIOD = 50*DIV + 1 + GAP;
    localparam int FIRST  = 50*DIV + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jd0, jd1, jc0, jc1, jl0, jl1, fd0, fd1;
    logic [15:0] a1, a2, b1, b2;
    logic [23:0] btn = '1;
    logic [23:0] sr0 = '1;
    logic [23:0] sr1 = '1;
    logic        pc0 = 1'b0;
    logic        pc1 = 1'b0;

    always #5 clk = ~clk;

    db15_serial_joy #(.DIV(DIV), .GAP(GAP), .FILTER(1'b0)) dut0 (
        .clk(clk), .reset(reset), .JOY_DATA(jd0), .JOY_CLK(jc0), .JOY_LOAD(jl0),
        .joystick1(a1), .joystick2(a2), .frame_done(fd0));

    db15_serial_joy #(.DIV(DIV), .GAP(GAP), .FILTER(1'b1)) dut1 (
        .clk(clk), .reset(reset), .JOY_DATA(jd1), .JOY_CLK(jc1), .JOY_LOAD(jl1),
        .joystick1(b1), .joystick2(b2), .frame_done(fd1));

    // External shift-register chain: parallel load while LOAD is low, shift on CLK rise.
    always @(posedge clk) begin
        if (!jl0) sr0 <= btn;
        else if (jc0 && !pc0) sr0 <= {1'b1, sr0[23:1]};
        pc0 <= jc0;
        if (!jl1) sr1 <= btn;
        else if (jc1 && !pc1) sr1 <= {1'b1, sr1[23:1]};
        pc1 <= jc1;
    end
    assign jd0 = sr0[0];
    assign jd1 = sr1[0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [15:0] j1; logic [15:0] j2; } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int failures = 0;
    int rel_cyc = 0;
    int last0 = 0, last1 = 0;
    bit first0 = 1'b1, first1 = 1'b1;
    bit pulse0 = 1'b0, pulse1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] e0j1, input logic [15:0] e0j2,
                        input logic [15:0] e1j1, input logic [15:0] e1j2);
        q0.push_back('{j1: e0j1, j2: e0j2});
        q1.push_back('{j1: e1j1, j2: e1j2});
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (fd0) break;
        end
        if (k == 1000) begin
            checks++;
            failures++;
            $display("FAIL %s: frame_done timeout got none expected pulse", tag);
        end
    endtask

    // Monitor: pops expectations on each frame_done and checks cadence and pulse width.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pulse0 = 1'b0;
            pulse1 = 1'b0;
        end else begin
            if (pulse0) begin chk("dut0_pulse_width", {31'd0, fd0}, 32'd0); pulse0 = 1'b0; end
            if (pulse1) begin chk("dut1_pulse_width", {31'd0, fd1}, 32'd0); pulse1 = 1'b0; end
            if (fd0) begin
                exp_t e;
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut0_unexpected_done: got pulse expected none");
                end else begin
                    e = q0.pop_front();
                    chk("dut0_joystick1", {16'd0, a1}, {16'd0, e.j1});
                    chk("dut0_joystick2", {16'd0, a2}, {16'd0, e.j2});
                end
                chk("dut0_period", cyc - (first0 ? rel_cyc : last0), first0 ? FIRST : PERIOD);
                first0 = 1'b0; last0 = cyc; pulse0 = 1'b1;
            end
            if (fd1) begin
                exp_t e;
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut1_unexpected_done: got pulse expected none");
                end else begin
                    e = q1.pop_front();
                    chk("dut1_joystick1", {16'd0, b1}, {16'd0, e.j1});
                    chk("dut1_joystick2", {16'd0, b2}, {16'd0, e.j2});
                end
                chk("dut1_period", cyc - (first1 ? rel_cyc : last1), first1 ? FIRST : PERIOD);
                first1 = 1'b0; last1 = cyc; pulse1 = 1'b1;
            end
        end
    end

    // Pressed-button masks per frame (serial bit k set = button k held).
    logic [23:0] pat [7] = '{24'h000008, 24'h800001, 24'h400000, 24'h400000,
                             24'h400010, 24'h400000, 24'h400000};
    logic [15:0] e0j1 [7] = '{16'h0008, 16'h0001, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000};
    logic [15:0] e0j2 [7] = '{16'h0000, 16'h0800, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
    logic [15:0] e1j2 [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'h0400, 16'h0400};

    initial begin
        int n;
        int rises;
        logic pj;
        reset = 1'b1;
        btn   = '1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_load",  {31'd0, jl0}, 32'd1);
            chk("rst_clk",   {31'd0, jc0}, 32'd0);
            chk("rst_done",  {31'd0, fd0}, 32'd0);
            chk("rst_joy",   {a1, a2}, 32'd0);
            chk("rst_load1", {31'd0, jl1}, 32'd1);
        end

        btn = ~pat[0];
        push(e0j1[0], e0j2[0], 16'h0000, e1j2[0]);
        reset = 1'b0; rel_cyc = cyc; first0 = 1'b1; first1 = 1'b1;

        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!jl0) n++;
            else if (n > 0) break;
        end
        chk("load_low_cycles", n, DIV);

        wait_done("frame1");
        for (int i = 1; i < 7; i++) begin
            btn = ~pat[i];
            push(e0j1[i], e0j2[i], 16'h0000, e1j2[i]);
            wait_done("frame_loop");
        end

        // Abort a frame during the high phase of bit 10.
        for (int k = 0; k < 1000 && jl0; k++) @(negedge clk);
        rises = 0; pj = jc0;
        for (int k = 0; k < 1000 && rises < 11; k++) begin
            @(negedge clk);
            if (jc0 && !pj) rises++;
            pj = jc0;
        end
        chk("bit10_reached", rises, 11);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_clk",  {31'd0, jc0}, 32'd0);
        chk("midrst_load", {31'd0, jl0}, 32'd1);
        chk("midrst_joy0", {a1, a2}, 32'd0);
        chk("midrst_joy1", {b1, b2}, 32'd0);
        @(negedge clk);
        btn = ~24'h000004;
        push(16'h0004, 16'h0000, 16'h0000, 16'h0000);
        push(16'h0004, 16'h0000, 16'h0004, 16'h0000);
        reset = 1'b0; rel_cyc = cyc; first0 = 1'b1; first1 = 1'b1;
        wait_done("post_rst1");
        wait_done("post_rst2");
        @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
